hilo_ctrl: RTL and testbench



---
 rtl/hilo_ctrl_pkg.sv | 30 +++
 rtl/div_iter.sv | 103 ++++++++++
 rtl/hilo_ctrl.sv | 129 ++++++++++++
 tb/tb_hilo_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_ctrl_pkg.sv
// Shared alucontrol codes, FSM state encoding and op-decode helpers for the HI/LO sequencer.
package hilo_ctrl_pkg;

    localparam int unsigned ALU_W = 6;

    localparam logic [ALU_W-1:0] MTHI_CONTROL  = 6'd17;
    localparam logic [ALU_W-1:0] MTLO_CONTROL  = 6'd19;
    localparam logic [ALU_W-1:0] MULT_CONTROL  = 6'd24;
    localparam logic [ALU_W-1:0] MULTU_CONTROL = 6'd25;
    localparam logic [ALU_W-1:0] DIV_CONTROL   = 6'd26;
    localparam logic [ALU_W-1:0] DIVU_CONTROL  = 6'd27;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_t;

    // Multi-cycle ops only; MTHI/MTLO complete without stalling.
    function automatic logic is_muldiv(logic [ALU_W-1:0] op);
        return (op == MULT_CONTROL) || (op == MULTU_CONTROL) ||
               (op == DIV_CONTROL)  || (op == DIVU_CONTROL);
    endfunction

    function automatic logic is_signed_op(logic [ALU_W-1:0] op);
        return (op == MULT_CONTROL) || (op == DIV_CONTROL);
    endfunction

endpackage

// File: rtl/div_iter.sv
// Radix-2 restoring divider: one quotient bit per cycle, sign fix-up and divide-by-zero handled here.
module div_iter #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              signed_op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    logic              run_q, run_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] dvs_q, dvs_d;
    logic              negq_q, negq_d;
    logic              negr_q, negr_d;
    logic              dz_q, dz_d;

    logic [DATA_W:0]   shifted, trial;
    logic [DATA_W-1:0] rem_n, quo_n, mag_a, mag_b;

    // One restoring step; quotient/remainder are the values after the current step.
    always_comb begin
        shifted = {rem_q, quo_q[DATA_W-1]};
        trial   = shifted - {1'b0, dvs_q};
        if (trial[DATA_W]) begin
            rem_n = shifted[DATA_W-1:0];
            quo_n = {quo_q[DATA_W-2:0], 1'b0};
        end else begin
            rem_n = trial[DATA_W-1:0];
            quo_n = {quo_q[DATA_W-2:0], 1'b1};
        end
        done      = run_q && (cnt_q == LAST) && !abort;
        quotient  = dz_q ? '1 : (negq_q ? -quo_n : quo_n);
        remainder = negr_q ? -rem_n : rem_n;
    end

    always_comb begin
        run_d  = run_q;
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        negq_d = negq_q;
        negr_d = negr_q;
        dz_d   = dz_q;
        mag_a  = (signed_op && a[DATA_W-1]) ? -a : a;
        mag_b  = (signed_op && b[DATA_W-1]) ? -b : b;
        if (abort) begin
            run_d = 1'b0;
        end else if (start) begin
            run_d  = 1'b1;
            cnt_d  = '0;
            rem_d  = '0;
            quo_d  = mag_a;
            dvs_d  = mag_b;
            dz_d   = (b == '0);
            // Quotient sign is dropped for /0 so lo stays all-ones; remainder then restores a.
            negq_d = signed_op && (a[DATA_W-1] ^ b[DATA_W-1]) && (b != '0);
            negr_d = signed_op && a[DATA_W-1];
        end else if (run_q) begin
            rem_d = rem_n;
            quo_d = quo_n;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q  <= 1'b0;
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            negq_q <= 1'b0;
            negr_q <= 1'b0;
            dz_q   <= 1'b0;
        end else begin
            run_q  <= run_d;
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            negq_q <= negq_d;
            negr_q <= negr_d;
            dz_q   <= dz_d;
        end
    end

endmodule

// File: rtl/hilo_ctrl.sv
// EX-stage HI/LO sequencer: MTHI/MTLO pass-through, registered multiply, iterative divide, single write strobe.
module hilo_ctrl
    import hilo_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic [5:0]        alucontrol,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              flush,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    output logic              stall_o,
    output logic              busy_o,
    output logic              hilo_we,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int unsigned PROD_W = 2 * DATA_W;

    state_t              state_q, state_d;
    logic [PROD_W-1:0]   res_q, res_d;
    logic                accept, signed_op;
    logic                div_start, div_done;
    logic [DATA_W-1:0]   div_quo, div_rem;
    logic [PROD_W-1:0]   a_ext, b_ext, prod;
    logic                we_c;
    logic [DATA_W-1:0]   hi_c, lo_c;

    // Operands are held by the stall through MUL, so the product is taken there.
    always_comb begin
        signed_op = is_signed_op(alucontrol);
        a_ext     = signed_op ? {{DATA_W{src_a[DATA_W-1]}}, src_a} : {{DATA_W{1'b0}}, src_a};
        b_ext     = signed_op ? {{DATA_W{src_b[DATA_W-1]}}, src_b} : {{DATA_W{1'b0}}, src_b};
        prod      = a_ext * b_ext;
        accept    = op_valid && !flush && (state_q == ST_IDLE);
    end

    always_comb begin
        state_d   = state_q;
        res_d     = res_q;
        div_start = 1'b0;
        we_c      = 1'b0;
        hi_c      = res_q[PROD_W-1:DATA_W];
        lo_c      = res_q[DATA_W-1:0];
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        case (alucontrol)
                            MULT_CONTROL, MULTU_CONTROL: state_d = ST_MUL;
                            DIV_CONTROL, DIVU_CONTROL: begin
                                state_d   = ST_DIV;
                                div_start = 1'b1;
                            end
                            MTHI_CONTROL: begin
                                we_c = 1'b1;
                                hi_c = src_a;
                                lo_c = lo_i;
                            end
                            MTLO_CONTROL: begin
                                we_c = 1'b1;
                                hi_c = hi_i;
                                lo_c = src_a;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    res_d   = prod;
                    state_d = ST_DONE;
                end
                ST_DIV: begin
                    if (div_done) begin
                        res_d   = {div_rem, div_quo};
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    we_c    = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Reset must silence the combinational write path immediately, not only at the next edge.
    always_comb begin
        stall_o = !rst && op_valid && is_muldiv(alucontrol) && (state_q != ST_DONE) && !flush;
        busy_o  = (state_q != ST_IDLE);
        hilo_we = !rst && we_c;
        hi_o    = rst ? '0 : hi_c;
        lo_o    = rst ? '0 : lo_c;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
        end
    end

    div_iter #(
        .DATA_W (DATA_W)
    ) u_div_iter (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .abort     (flush),
        .signed_op (signed_op),
        .a         (src_a),
        .b         (src_b),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

endmodule

// File: tb/tb_hilo_ctrl.sv
// Scoreboard bench for hilo_ctrl: stimulus pushes expected writes, a negedge monitor pops and compares.
module tb_hilo_ctrl;
    import hilo_ctrl_pkg::*;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         op_valid;
    logic [5:0]   alucontrol;
    logic [W-1:0] src_a, src_b, hi_i, lo_i;
    logic         flush;
    logic         stall_o, busy_o, hilo_we;
    logic [W-1:0] hi_o, lo_o;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           cyc;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    hilo_ctrl #(.DATA_W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .alucontrol (alucontrol),
        .src_a      (src_a),
        .src_b      (src_b),
        .flush      (flush),
        .hi_i       (hi_i),
        .lo_i       (lo_i),
        .stall_o    (stall_o),
        .busy_o     (busy_o),
        .hilo_we    (hilo_we),
        .hi_o       (hi_o),
        .lo_o       (lo_o)
    );

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && hilo_we !== 1'b0) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_we: got hilo_we=%b expected 0 (cycle %0d)", hilo_we, cyc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("hi_o", 64'(hi_o), 64'(e.hi));
                check("lo_o", 64'(lo_o), 64'(e.lo));
                check("we_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Reference: returns {hi,lo}; lat is stall cycles (= cycles from accept to write).
    function automatic logic [63:0] model(input logic [5:0] op, input logic [W-1:0] a, b, hi, lo,
                                          output int lat, output bit wr);
        logic signed [63:0] sa, sb, ma, mb, q, r;
        logic [63:0]        p;
        lat = 0;
        wr  = 1'b1;
        p   = '0;
        case (op)
            MTHI_CONTROL: p = {a, lo};
            MTLO_CONTROL: p = {hi, a};
            MULT_CONTROL: begin
                lat = 2;
                p   = 64'(longint'($signed(a)) * longint'($signed(b)));
            end
            MULTU_CONTROL: begin
                lat = 2;
                p   = 64'(a) * 64'(b);
            end
            DIV_CONTROL, DIVU_CONTROL: begin
                lat = 33;
                if (b == '0) begin
                    p = {a, 32'hFFFF_FFFF};
                end else if (op == DIVU_CONTROL) begin
                    p = {32'(a % b), 32'(a / b)};
                end else begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    ma = (sa < 0) ? -sa : sa;
                    mb = (sb < 0) ? -sb : sb;
                    q  = ma / mb;
                    r  = ma % mb;
                    if ((sa < 0) != (sb < 0)) q = -q;
                    if (sa < 0) r = -r;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: wr = 1'b0;
        endcase
        return p;
    endfunction

    // Present one instruction and hold it until the stall releases.
    task automatic issue(input logic [5:0] op, input logic [W-1:0] a, b, hi, lo);
        logic [63:0] r;
        int          lat, stalls;
        bit          wr, ok;
        op_valid = 1'b1;
        alucontrol = op;
        src_a = a;
        src_b = b;
        hi_i = hi;
        lo_i = lo;
        r = model(op, a, b, hi, lo, lat, wr);
        if (wr) sbq.push_back('{r[63:32], r[31:0], cyc + lat});
        stalls = 0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (stall_o === 1'b1) stalls++;
            else begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stall_timeout: got >=100 stall cycles expected %0d", lat);
        end
        check("stall_cycles", 64'(stalls), 64'(lat));
        check("busy_at_retire", 64'(busy_o), 64'(lat > 0));
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    // Start a mul/div and flush it k cycles after accept; nothing may be written.
    task automatic flush_op(input logic [5:0] op, input logic [W-1:0] a, b, input int k);
        op_valid = 1'b1;
        alucontrol = op;
        src_a = a;
        src_b = b;
        hi_i = $urandom;
        lo_i = $urandom;
        repeat (k) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        check("stall_in_flush", 64'(stall_o), 64'(0));
        @(posedge clk);
        #1;
        flush = 1'b0;
        op_valid = 1'b0;
        @(negedge clk);
        check("busy_after_flush", 64'(busy_o), 64'(0));
    endtask

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return 32'h8000_0000;
            3: return W'($urandom_range(0, 20));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        logic [5:0] ops[6];
        logic [5:0] op;
        ops = '{MTHI_CONTROL, MTLO_CONTROL, MULT_CONTROL, MULTU_CONTROL, DIV_CONTROL, DIVU_CONTROL};
        rst = 1'b1;
        flush = 1'b0;
        op_valid = 1'b1;
        alucontrol = MTHI_CONTROL;
        src_a = 32'hDEAD_BEEF;
        src_b = '0;
        hi_i = 32'h1111_1111;
        lo_i = 32'h2222_2222;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 64'(stall_o), 64'(0));
        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_we", 64'(hilo_we), 64'(0));
        check("rst_hi", 64'(hi_o), 64'(0));
        check("rst_lo", 64'(lo_o), 64'(0));
        op_valid = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        issue(MTHI_CONTROL, 32'h1234_5678, 32'h0, 32'h0, 32'hAAAA_0000);
        issue(MTLO_CONTROL, 32'hCAFE_F00D, 32'h0, 32'h5555_5555, 32'h0);
        issue(MULT_CONTROL, 32'hFFFF_FFFE, 32'd3, 32'h0, 32'h0);
        issue(MULTU_CONTROL, 32'hFFFF_FFFE, 32'd3, 32'h0, 32'h0);
        issue(DIV_CONTROL, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'h0);
        issue(DIVU_CONTROL, 32'd100, 32'd7, 32'h0, 32'h0);
        issue(DIVU_CONTROL, 32'h55, 32'h0, 32'h0, 32'h0);
        issue(DIV_CONTROL, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h0);
        issue(6'd5, 32'h1, 32'h2, 32'h0, 32'h0);

        flush_op(DIV_CONTROL, 32'd1000, 32'd3, 10);
        repeat (40) @(posedge clk);
        #1;
        issue(MULT_CONTROL, 32'd7, 32'hFFFF_FFFD, 32'h0, 32'h0);
        flush_op(MULT_CONTROL, 32'd5, 32'd6, 2);
        flush_op(DIVU_CONTROL, 32'd50, 32'd5, 33);
        flush_op(DIV_CONTROL, 32'd50, 32'd5, 32);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a divide.
        op_valid = 1'b1;
        alucontrol = DIV_CONTROL;
        src_a = 32'd12345;
        src_b = 32'd17;
        repeat (15) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_stall", 64'(stall_o), 64'(0));
        check("mid_rst_busy", 64'(busy_o), 64'(0));
        check("mid_rst_we", 64'(hilo_we), 64'(0));
        check("mid_rst_hi", 64'(hi_o), 64'(0));
        check("mid_rst_lo", 64'(lo_o), 64'(0));
        op_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        issue(DIVU_CONTROL, 32'd9, 32'd3, 32'h0, 32'h0);

        for (int n = 0; n < 60; n++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            if ($urandom_range(0, 7) == 0) op = 6'(($urandom_range(0, 15) * 4) + 1);
            else op = ops[$urandom_range(0, 5)];
            if (is_muldiv(op) && $urandom_range(0, 5) == 0)
                flush_op(op, rnd_val(), rnd_val(),
                         (op == MULT_CONTROL || op == MULTU_CONTROL) ? $urandom_range(0, 2)
                                                                     : $urandom_range(0, 33));
            else
                issue(op, rnd_val(), rnd_val(), W'($urandom), W'($urandom));
            @(posedge clk);
            #1;
        end

        repeat (5) @(posedge clk);
        check("sb_empty", 64'(sbq.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
